pixel_buffer: RTL
=================

PIXEL_BUFFER -- requirements
Module: pixel_buffer

Interface
REQ-001 Parameter DEPTH, 16, entry capacity; power of two, 4 to 64.
REQ-002 Parameter PIX_W, 19, pixelID width (640x480 frame).
REQ-003 Parameter COLOR_W, 24, color width (8b R, G, B).
REQ-004 Parameter NUM_PIXELS, 307200, pixels per frame.
REQ-005 Port clk  in  1  sole clock, rising edge.
REQ-006 Port rst  in  1  reset, synchronous, active-high.
REQ-007 Port pb_we  in  1  shader write strobe.
REQ-008 Port pb_data_in  in  PIX_W+COLOR_W  entry {pixelID, color}, pixelID in the MSBs.
REQ-009 Port pb_full  out  1  no space; the shader SHALL NOT write while high.
REQ-010 Port fb_wr_req  out  1  frame-buffer write request.
REQ-011 Port fb_wr_addr  out  PIX_W  pixelID of the pending write.
REQ-012 Port fb_wr_data  out  COLOR_W  color of the pending write.
REQ-013 Port fb_wr_ack  in  1  frame-buffer accepted the pending write this cycle.
REQ-014 Port frame_done  out  1  one-cycle pulse when a full frame has been written.
REQ-015 Port pb_overflow  out  1  sticky error flag; present only with PB_OVERFLOW_CHECK_EN.

Function
REQ-016 Storage SHALL be a FIFO of DEPTH entries with registered occupancy count; pb_full = (count == DEPTH), combinational from count only.
REQ-017 A write SHALL be accepted iff pb_we & ~pb_full; an accepted entry is stored at the rising edge ending that cycle.
REQ-018 pb_we while pb_full SHALL drop the entry; a pop in the same cycle SHALL NOT make room for it.
REQ-019 The drain FSM SHALL have two states. IDLE: fb_wr_req=0. REQ: fb_wr_req=1, fb_wr_addr/fb_wr_data driven from an output register.
REQ-020 IDLE with FIFO non-empty SHALL pop the head into the output register and go to REQ.
REQ-021 REQ with fb_wr_ack and FIFO non-empty SHALL pop the next entry and stay in REQ (back-to-back, one write per cycle).
REQ-022 REQ with fb_wr_ack and FIFO empty SHALL go to IDLE; REQ without ack SHALL hold the request and output data unchanged.
REQ-023 fb_wr_ack while in IDLE SHALL be ignored.
REQ-024 Latency: pb_we accepted in cycle 0 into an empty, idle buffer SHALL give fb_wr_req high in cycle 2.
REQ-025 Order SHALL be strictly FIFO; entries are never reordered, merged or duplicated.
REQ-026 Simultaneous accept and pop SHALL leave count unchanged; count never exceeds DEPTH or goes below 0.
REQ-027 A frame counter (ceil(log2(NUM_PIXELS)) bits) SHALL increment on each cycle with fb_wr_req & fb_wr_ack.
REQ-028 The ack that takes the counter from NUM_PIXELS-1 SHALL wrap it to 0 and pulse frame_done high for exactly the next cycle.
REQ-029 The frame counter SHALL count acknowledged writes only; pixelID values SHALL NOT be decoded.

Reset
REQ-030 rst sampled high SHALL reset in one cycle: count=0, FSM=IDLE, frame counter=0, pb_full=0, fb_wr_req=0, frame_done=0, pb_overflow=0, fb_wr_addr=0, fb_wr_data=0.
REQ-031 rst during REQ SHALL discard the pending write and all buffered entries; fb_wr_ack in the reset cycle SHALL be ignored.
REQ-032 pb_we SHALL be ignored in any cycle where rst is high.

Configuration
REQ-033 Macro PB_OVERFLOW_CHECK_EN defined: pb_overflow SHALL go high the cycle after any pb_we & pb_full and stay high until rst.
REQ-034 Macro PB_OVERFLOW_CHECK_EN undefined: the pb_overflow port and its logic SHALL be absent; all other behaviour is identical.

Verification
REQ-035 Single write {pixelID=5, color=0xFF0000} into an empty buffer, fb_wr_ack tied high -> fb_wr_req high in cycle 2 with addr 5, data 0xFF0000; FSM back to IDLE in cycle 3.
REQ-036 DEPTH=16, fb_wr_ack held low, 17 consecutive writes -> pb_full high after the 16th; the 17th is dropped, pb_overflow=1 with the macro; after ack is released, exactly 16 writes appear in order.
REQ-037 Continuous writes with fb_wr_ack tied high -> one fb write per cycle, no bubbles, pb_full never asserted.
REQ-038 NUM_PIXELS overridden to 8, 8 acked writes -> frame_done pulses once, one cycle after the 8th ack; the 9th ack does not pulse it.
REQ-039 rst asserted while in REQ with 3 entries buffered -> the next cycle has fb_wr_req=0, pb_full=0 and count 0; a new write then appears after the 2-cycle latency.

Source files
------------

// File: rtl/pixel_buffer.sv
// Pixel buffer between a shader and the frame buffer: a DEPTH-entry FIFO drained by a two-state write FSM.
// Optional sticky overflow flag is compiled in with `define PB_OVERFLOW_CHECK_EN.
module pixel_buffer #(
    parameter int DEPTH      = 16,
    parameter int PIX_W      = 19,
    parameter int COLOR_W    = 24,
    parameter int NUM_PIXELS = 307200
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     pb_we,
    input  logic [PIX_W+COLOR_W-1:0] pb_data_in,
    output logic                     pb_full,
    output logic                     fb_wr_req,
    output logic [PIX_W-1:0]         fb_wr_addr,
    output logic [COLOR_W-1:0]       fb_wr_data,
    input  logic                     fb_wr_ack,
    output logic                     frame_done
`ifdef PB_OVERFLOW_CHECK_EN
    ,
    output logic                     pb_overflow
`endif
);

    localparam int ENTRY_W = PIX_W + COLOR_W;
    localparam int PTR_W   = $clog2(DEPTH);
    localparam int CNT_W   = PTR_W + 1;
    localparam int FRAME_W = (NUM_PIXELS > 1) ? $clog2(NUM_PIXELS) : 1;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_REQ  = 1'b1;

    logic [ENTRY_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [0:0]         state_q, state_d;
    logic [ENTRY_W-1:0] out_q, out_d;
    logic [FRAME_W-1:0] frame_cnt_q, frame_cnt_d;
    logic               frame_done_q, frame_done_d;

    logic accept;
    logic fire;
    logic head_valid;
    logic load;
    logic frame_last;

    // count_q includes the entry being presented, so a slot frees only when its write is acked.
    assign pb_full    = (count_q == CNT_W'(DEPTH));
    assign accept     = pb_we & ~pb_full & ~rst;
    assign fire       = (state_q == ST_REQ) & fb_wr_ack;
    assign head_valid = (state_q == ST_IDLE) ? (count_q != '0) : (count_q > CNT_W'(1));
    assign load       = head_valid & ((state_q == ST_IDLE) | fb_wr_ack);
    assign frame_last = (frame_cnt_q == FRAME_W'(NUM_PIXELS - 1));

    assign fb_wr_req  = (state_q == ST_REQ);
    assign fb_wr_addr = out_q[ENTRY_W-1 -: PIX_W];
    assign fb_wr_data = out_q[COLOR_W-1:0];
    assign frame_done = frame_done_q;

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        count_d      = count_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        out_d        = out_q;
        state_d      = state_q;
        frame_cnt_d  = frame_cnt_q;
        frame_done_d = 1'b0;

        case ({accept, fire})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase

        if (accept) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end

        if (load) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
            out_d    = mem_q[rd_ptr_q];
        end

        case (state_q)
            ST_IDLE: if (load) state_d = ST_REQ;
            ST_REQ:  if (fb_wr_ack && !head_valid) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        if (fire) begin
            frame_cnt_d  = frame_last ? '0 : frame_cnt_q + 1'b1;
            frame_done_d = frame_last;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q      <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            out_q        <= '0;
            state_q      <= ST_IDLE;
            frame_cnt_q  <= '0;
            frame_done_q <= 1'b0;
        end else begin
            count_q      <= count_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            out_q        <= out_d;
            state_q      <= state_d;
            frame_cnt_q  <= frame_cnt_d;
            frame_done_q <= frame_done_d;
        end
    end

    // NOTE: storage is not reset; count_q and the pointers alone decide which slots hold valid data.
    always_ff @(posedge clk) begin
        if (accept) begin
            mem_q[wr_ptr_q] <= pb_data_in;
        end
    end

`ifdef PB_OVERFLOW_CHECK_EN
    logic overflow_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            overflow_q <= 1'b0;
        end else if (pb_we && pb_full) begin
            overflow_q <= 1'b1;
        end
    end

    assign pb_overflow = overflow_q;
`endif

endmodule
